envm_test_store: RTL and testbench
==================================

ENVM_TEST_STORE -- requirements
Module: envm_test_store

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, PE array dimension S.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, weight bits W.
REQ-003 SHALL have parameter ACTIVATION_WIDTH, default 8, activation bits A.
REQ-004 SHALL have parameter PARTIAL_SUM_WIDTH, default W+A+$clog2(S), psum/answer bits P.
REQ-005 SHALL have parameter SA_DEPTH, default 12, stuck-at pattern count.
REQ-006 SHALL have parameter TD_DEPTH, default 18, transition-delay pattern count; localparam PTR_WIDTH = $clog2(max(SA_DEPTH,TD_DEPTH)).
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port load_en  input  1  pattern write strobe.
REQ-010 SHALL have port load_type  input  1  0 SA, 1 TD.
REQ-011 SHALL have port load_slot  input  1  TD slot: 0 launch, 1 capture; ignored for SA.
REQ-012 SHALL have port load_addr  input  PTR_WIDTH  pattern index.
REQ-013 SHALL have port load_data  input  W+A+2P  {weight, activation, psum_in, answer}, MSB first.
REQ-014 SHALL have port start  input  1  begin sequence, single-cycle pulse.
REQ-015 SHALL have port start_type  input  1  0 SA, 1 TD; sampled with start.
REQ-016 SHALL have port abort  input  1  cancel sequence.
REQ-017 SHALL have port busy  output  1  sequencer in RUN.
REQ-018 SHALL have port done  output  1  one-cycle pulse after last beat accepted.
REQ-019 SHALL have port scan_valid  output  1  beat valid.
REQ-020 SHALL have port scan_ready  input  1  consumer accepts beat.
REQ-021 SHALL have port scan_weight  output  W  beat weight.
REQ-022 SHALL have port scan_activation  output  A  beat activation.
REQ-023 SHALL have port scan_psum_in  output  P  beat partial-sum input.
REQ-024 SHALL have port scan_answer  output  P  beat golden answer.
REQ-025 SHALL have port scan_index  output  PTR_WIDTH  pattern index of beat.
REQ-026 SHALL have port scan_phase  output  1  0 launch/SA, 1 capture.
REQ-027 SHALL have port det_en  input  1  fault-map update strobe.
REQ-028 SHALL have port det_addr  input  $clog2(S)  fault-map row.
REQ-029 SHALL have port single_pe_detection  input  S  per-PE fault flags of row.
REQ-030 SHALL have port fault_clear  input  1  synchronous fault-map clear.
REQ-031 SHALL have port envm_faulty_patterns_flat  output  S*S  row i at bits [i*S +: S].

Function
REQ-032 Load: load_en && !busy && load_addr < depth(load_type) SHALL write load_data into entry [type][slot][addr] at clock edge; otherwise write dropped; SA ignores load_slot.
REQ-033 FSM SHALL have states IDLE, RUN; start in IDLE latches start_type, index=0, phase=0, enters RUN; start in RUN ignored.
REQ-034 Beat order: SA = index 0..SA_DEPTH-1, phase 0; TD = per index phase 0 (launch slot, launch answer) then phase 1 (capture slot, capture answer).
REQ-035 All scan_* SHALL be registered; scan_valid rises the cycle after start; on each scan_valid && scan_ready edge the next beat loads, giving one beat per cycle with scan_ready held high.
REQ-036 While scan_valid && !scan_ready, all scan_* SHALL hold stable; no beat skipped or repeated.
REQ-037 On acceptance of last beat: scan_valid=0, done=1 for one cycle, return to IDLE, busy=0 same cycle as done.
REQ-038 abort SHALL override start and handshake: next edge IDLE, scan_valid=0, no done pulse.
REQ-039 Fault map: det_en SHALL set row[det_addr] <= row[det_addr] | single_pe_detection (OR-accumulate); det_addr >= S ignored; fault_clear zeroes all rows and wins over det_en; map independent of FSM.

Reset
REQ-040 rst_n low SHALL immediately force IDLE, busy=0, done=0, scan_valid=0, scan data/index/phase=0, fault map=0; pattern arrays not reset.

Verification
REQ-041 Load SA 0..11 with weight=addr, answer=addr+100; start type 0, ready=1 -> 12 consecutive beats, index 0..11, answer 100..111, done after beat 11.
REQ-042 Load TD launch answer=addr, capture answer=addr+50; start type 1 -> 36 beats, phase 0/1 alternating, answers 0,50,1,51,..,17,67.
REQ-043 Drop scan_ready 3 cycles at beat 5 -> beat 5 held unchanged, delivered once, beat 6 follows.
REQ-044 abort at beat 4 -> next cycle scan_valid=0, busy=0, no done; new start restarts at index 0.
REQ-045 det row 2 = 0x05 then 0x30 -> flat[23:16]=0x35; fault_clear with det_en -> all 0.
REQ-046 load_en while busy or load_addr=SA_DEPTH for SA -> stored data unchanged on rerun.

Source files
------------

// File: rtl/envm_test_store_if.sv
// Scan-beat stream between the eNVM test-pattern store and the PE-array test harness.
// Registered beat fields travel with a valid/ready handshake.
interface envm_test_store_if #(
  parameter int W  = 8,
  parameter int A  = 8,
  parameter int P  = 19,
  parameter int IW = 5
);
  logic          scan_valid;
  logic          scan_ready;
  logic [W-1:0]  scan_weight;
  logic [A-1:0]  scan_activation;
  logic [P-1:0]  scan_psum_in;
  logic [P-1:0]  scan_answer;
  logic [IW-1:0] scan_index;
  logic          scan_phase;

  modport master (
    output scan_valid, scan_weight, scan_activation, scan_psum_in,
           scan_answer, scan_index, scan_phase,
    input  scan_ready
  );

  modport slave (
    input  scan_valid, scan_weight, scan_activation, scan_psum_in,
           scan_answer, scan_index, scan_phase,
    output scan_ready
  );
endinterface

// File: rtl/envm_test_store.sv
// Stores stuck-at / transition-delay test patterns and streams them as scan beats;
// also accumulates a per-PE fault map reported by the array under test.
module envm_test_store #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int SA_DEPTH          = 12,
  parameter int TD_DEPTH          = 18,
  localparam int PTR_WIDTH = $clog2((SA_DEPTH > TD_DEPTH) ? SA_DEPTH : TD_DEPTH),
  localparam int LD_W      = WEIGHT_WIDTH + ACTIVATION_WIDTH + 2*PARTIAL_SUM_WIDTH,
  localparam int DA_W      = $clog2(SYSTOLIC_SIZE)
)(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   load_en,
  input  logic                                   load_type,
  input  logic                                   load_slot,
  input  logic [PTR_WIDTH-1:0]                   load_addr,
  input  logic [LD_W-1:0]                        load_data,
  input  logic                                   start,
  input  logic                                   start_type,
  input  logic                                   abort,
  output logic                                   busy,
  output logic                                   done,
  envm_test_store_if.master                      scan,
  input  logic                                   det_en,
  input  logic [DA_W-1:0]                        det_addr,
  input  logic [SYSTOLIC_SIZE-1:0]               single_pe_detection,
  input  logic                                   fault_clear,
  output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] envm_faulty_patterns_flat
);
  localparam int S     = SYSTOLIC_SIZE;
  localparam int P     = PARTIAL_SUM_WIDTH;
  localparam int MEM_D = 2**PTR_WIDTH;
  localparam logic [PTR_WIDTH:0]   SA_D    = (PTR_WIDTH+1)'(SA_DEPTH);
  localparam logic [PTR_WIDTH:0]   TD_D    = (PTR_WIDTH+1)'(TD_DEPTH);
  localparam logic [PTR_WIDTH-1:0] SA_LAST = PTR_WIDTH'(SA_DEPTH-1);
  localparam logic [PTR_WIDTH-1:0] TD_LAST = PTR_WIDTH'(TD_DEPTH-1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e               state_q, state_d;
  logic                 type_q, type_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 phase_q, phase_d;
  logic [PTR_WIDTH-1:0] idx_q, idx_d;
  logic [LD_W-1:0]      beat_q, beat_d;

  // Pattern storage is not reset; memories are sized to the pointer range so
  // any pointer value indexes safely, only in-range entries are ever written.
  logic [LD_W-1:0] sa_mem [MEM_D];
  logic [LD_W-1:0] td_mem [2][MEM_D];

  always_ff @(posedge clk) begin
    if (load_en && state_q == IDLE) begin
      if (!load_type && ({1'b0, load_addr} < SA_D)) sa_mem[load_addr] <= load_data;
      if ( load_type && ({1'b0, load_addr} < TD_D)) td_mem[load_slot][load_addr] <= load_data;
    end
  end

  logic                 last, load_beat, ntype, nphase;
  logic [PTR_WIDTH-1:0] nidx;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    phase_d   = phase_q;
    idx_d     = idx_q;
    beat_d    = beat_q;
    ntype     = type_q;
    nidx      = idx_q;
    nphase    = phase_q;
    load_beat = 1'b0;
    last      = type_q ? (idx_q == TD_LAST && phase_q) : (idx_q == SA_LAST);
    case (state_q)
      IDLE: if (start) begin
        ntype     = start_type;
        nidx      = '0;
        nphase    = 1'b0;
        load_beat = 1'b1;
        state_d   = RUN;
      end
      RUN: if (valid_q && scan.scan_ready) begin
        if (last) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          load_beat = 1'b1;
          // TD visits launch then capture of the same index before advancing
          if (type_q && !phase_q) nphase = 1'b1;
          else begin
            nphase = 1'b0;
            nidx   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_beat) begin
      type_d  = ntype;
      idx_d   = nidx;
      phase_d = nphase;
      beat_d  = ntype ? td_mem[nphase][nidx] : sa_mem[nidx];
      valid_d = 1'b1;
    end
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      type_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 1'b0;
      idx_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
    end
  end

  assign busy                 = (state_q == RUN);
  assign done                 = done_q;
  assign scan.scan_valid      = valid_q;
  assign scan.scan_index      = idx_q;
  assign scan.scan_phase      = phase_q;
  assign scan.scan_answer     = beat_q[P-1:0];
  assign scan.scan_psum_in    = beat_q[2*P-1:P];
  assign scan.scan_activation = beat_q[2*P +: ACTIVATION_WIDTH];
  assign scan.scan_weight     = beat_q[LD_W-1 -: WEIGHT_WIDTH];

  // Fault map: OR-accumulate per row, clear has priority
  logic [S-1:0][S-1:0] fmap_q, fmap_d;

  always_comb begin
    fmap_d = fmap_q;
    if (fault_clear) fmap_d = '0;
    else if (det_en) begin
      for (int r = 0; r < S; r++)
        if (det_addr == DA_W'(r)) fmap_d[r] = fmap_q[r] | single_pe_detection;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fmap_q <= '0;
    else        fmap_q <= fmap_d;
  end

  assign envm_faulty_patterns_flat = fmap_q;
endmodule

// File: tb/tb_envm_test_store.sv
// Bench for envm_test_store: directed pattern runs, stall/abort corners, load guards,
// table-driven fault-map vectors, and randomized traffic against a behavioural model.
module tb_envm_test_store;
  localparam int S   = 8;
  localparam int W   = 8;
  localparam int A   = 8;
  localparam int P   = W + A + $clog2(S);
  localparam int SAD = 12;
  localparam int TDD = 18;
  localparam int PW  = $clog2(TDD);
  localparam int LW  = W + A + 2*P;

  logic clk = 1'b0, rst_n = 1'b1;
  logic load_en = 1'b0, load_type = 1'b0, load_slot = 1'b0;
  logic [PW-1:0] load_addr = '0;
  logic [LW-1:0] load_data = '0;
  logic start = 1'b0, start_type = 1'b0, abort = 1'b0;
  logic busy, done;
  logic det_en = 1'b0, fault_clear = 1'b0;
  logic [2:0] det_addr = '0;
  logic [S-1:0] spd = '0;
  logic [S*S-1:0] flat;

  envm_test_store_if #(.W(W), .A(A), .P(P), .IW(PW)) sif ();

  envm_test_store #(.SYSTOLIC_SIZE(S), .WEIGHT_WIDTH(W), .ACTIVATION_WIDTH(A),
                    .SA_DEPTH(SAD), .TD_DEPTH(TDD)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_type(load_type),
    .load_slot(load_slot), .load_addr(load_addr), .load_data(load_data),
    .start(start), .start_type(start_type), .abort(abort), .busy(busy), .done(done),
    .scan(sif.master), .det_en(det_en), .det_addr(det_addr),
    .single_pe_detection(spd), .fault_clear(fault_clear),
    .envm_faulty_patterns_flat(flat)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [LW-1:0] sa_ref [SAD];
  logic [LW-1:0] td_ref [2][TDD];
  logic [S-1:0]  fm_ref [S];

  typedef struct {
    bit          en;
    logic [2:0]  addr;
    logic [7:0]  pe;
    bit          clr;
    logic [63:0] exp;
  } fvec_t;
  fvec_t ft [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [LW-1:0] mk(input int w, input int a, input int ps, input int an);
    return {W'(w), A'(a), P'(ps), P'(an)};
  endfunction

  // Called at a negedge while idle; the model keeps only writes the store should accept.
  task automatic do_load(input bit t, input bit s, input int addr, input logic [LW-1:0] d);
    load_en = 1'b1; load_type = t; load_slot = s; load_addr = PW'(addr); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    if (!t && addr < SAD) sa_ref[addr] = d;
    else if (t && addr < TDD) td_ref[s][addr] = d;
  endtask

  task automatic run_seq(input bit typ, input int stall_pct, input int stall_at,
                         input int stall_len, input int abort_at, input bit noise);
    logic [LW-1:0] exp_d[$];
    int            exp_i[$];
    bit            exp_p[$];
    int            n, got, scnt;
    bit            stalled, r, fin;
    logic [LW+PW:0] prev, cur;
    got = 0; scnt = 0; stalled = 1'b0; fin = 1'b0; prev = '0;
    n = typ ? 2*TDD : SAD;
    for (int k = 0; k < n; k++) begin
      int ix;
      bit ph;
      ix = typ ? k/2 : k;
      ph = typ ? bit'(k % 2) : 1'b0;
      exp_d.push_back(typ ? td_ref[ph][ix] : sa_ref[ix]);
      exp_i.push_back(ix);
      exp_p.push_back(ph);
    end
    sif.scan_ready = 1'b0;
    start = 1'b1; start_type = typ;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      cur = {sif.scan_weight, sif.scan_activation, sif.scan_psum_in, sif.scan_answer,
             sif.scan_index, sif.scan_phase};
      chk("scan_valid_in_run", sif.scan_valid, 1);
      if (!sif.scan_valid) fin = 1'b1;
      else begin
        if (stalled) chk("stall_hold", cur, prev);
        if (got == abort_at) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0; load_en = 1'b0; sif.scan_ready = 1'b0;
          chk("abort_valid", sif.scan_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_done", done, 0);
          @(negedge clk);
          chk("abort_no_done", done, 0);
          return;
        end
        if (got == stall_at && scnt < stall_len) begin r = 1'b0; scnt++; end
        else r = ($urandom_range(99) >= stall_pct);
        sif.scan_ready = r;
        if (noise) begin
          load_en = 1'b1; load_type = 1'($urandom); load_slot = 1'($urandom);
          load_addr = PW'($urandom_range(17)); load_data = LW'({$urandom, $urandom});
        end
        if (r) begin
          chk("beat_data", cur[LW+PW:PW+1], exp_d[got]);
          chk("beat_index", cur[PW:1], exp_i[got]);
          chk("beat_phase", cur[0], exp_p[got]);
          got++;
        end
        stalled = !r; prev = cur;
        if (r && got == n) begin
          @(negedge clk);
          sif.scan_ready = 1'b0; load_en = 1'b0;
          chk("done_pulse", done, 1);
          chk("busy_at_done", busy, 0);
          chk("valid_at_done", sif.scan_valid, 0);
          @(negedge clk);
          chk("done_one_cycle", done, 0);
          return;
        end
      end
      @(negedge clk);
    end
    load_en = 1'b0; sif.scan_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("run_beats_total", got, n);
  endtask

  initial begin
    logic [63:0] exp_flat;
    sif.scan_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", sif.scan_valid, 0);
    chk("rst_data", {sif.scan_weight, sif.scan_activation, sif.scan_psum_in, sif.scan_answer}, 0);
    chk("rst_index_phase", {sif.scan_index, sif.scan_phase}, 0);
    chk("rst_fmap", flat, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SA: weight=addr, answer=addr+100; TD: launch answer=addr, capture answer=addr+50
    for (int i = 0; i < SAD; i++) do_load(1'b0, 1'($urandom), i, mk(i, 3*i, 7*i, i + 100));
    for (int i = 0; i < TDD; i++) begin
      do_load(1'b1, 1'b0, i, mk($urandom_range(255), $urandom_range(255), $urandom_range(999), i));
      do_load(1'b1, 1'b1, i, mk($urandom_range(255), $urandom_range(255), $urandom_range(999), i + 50));
    end
    do_load(1'b0, 1'b0, SAD, mk(255, 255, 1, 1));   // out of range, must be dropped

    run_seq(1'b0, 0, -1, 0, -1, 1'b0);
    run_seq(1'b1, 0, -1, 0, -1, 1'b0);
    run_seq(1'b0, 0, 5, 3, -1, 1'b0);
    run_seq(1'b0, 0, -1, 0, 4, 1'b0);
    run_seq(1'b0, 0, -1, 0, -1, 1'b0);
    run_seq(1'b1, 30, -1, 0, -1, 1'b1);   // loads while busy are ignored
    run_seq(1'b0, 30, -1, 0, -1, 1'b1);
    run_seq(1'b1, 0, -1, 0, -1, 1'b0);

    // Random loads (some out of range) then randomly stalled runs
    for (int i = 0; i < 40; i++)
      do_load(1'($urandom), 1'($urandom), $urandom_range(31), LW'({$urandom, $urandom}));
    for (int i = 0; i < 4; i++) run_seq(1'($urandom), 40, -1, 0, -1, 1'b0);

    ft[0] = '{1'b1, 3'd2, 8'h05, 1'b0, 64'h0000_0000_0005_0000};
    ft[1] = '{1'b1, 3'd2, 8'h30, 1'b0, 64'h0000_0000_0035_0000};
    ft[2] = '{1'b1, 3'd7, 8'h81, 1'b0, 64'h8100_0000_0035_0000};
    ft[3] = '{1'b0, 3'd0, 8'hFF, 1'b0, 64'h8100_0000_0035_0000};
    ft[4] = '{1'b1, 3'd1, 8'hFF, 1'b1, 64'h0000_0000_0000_0000};
    ft[5] = '{1'b1, 3'd0, 8'h0F, 1'b0, 64'h0000_0000_0000_000F};
    ft[6] = '{1'b0, 3'd0, 8'h00, 1'b1, 64'h0000_0000_0000_0000};
    for (int i = 0; i < 7; i++) begin
      det_en = ft[i].en; det_addr = ft[i].addr; spd = ft[i].pe; fault_clear = ft[i].clr;
      @(negedge clk);
      det_en = 1'b0; fault_clear = 1'b0;
      chk("fmap_vec", flat, ft[i].exp);
    end

    for (int r = 0; r < S; r++) fm_ref[r] = '0;
    for (int i = 0; i < 40; i++) begin
      det_en = 1'($urandom); det_addr = 3'($urandom); spd = 8'($urandom);
      fault_clear = ($urandom_range(9) == 0);
      if (fault_clear) for (int r = 0; r < S; r++) fm_ref[r] = '0;
      else if (det_en) fm_ref[det_addr] = fm_ref[det_addr] | spd;
      @(negedge clk);
      for (int r = 0; r < S; r++) exp_flat[r*S +: S] = fm_ref[r];
      chk("fmap_rand", flat, exp_flat);
    end
    det_en = 1'b1; det_addr = 3'd5; spd = 8'hA5; fault_clear = 1'b0;
    @(negedge clk);
    det_en = 1'b0;

    // Asynchronous reset in the middle of a run, away from any clock edge
    sif.scan_ready = 1'b1; start = 1'b1; start_type = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", sif.scan_valid, 0);
    chk("async_rst_index", sif.scan_index, 0);
    chk("async_rst_fmap", flat, 0);
    @(negedge clk);
    rst_n = 1'b1; sif.scan_ready = 1'b0;
    @(negedge clk);
    run_seq(1'b0, 0, -1, 0, -1, 1'b0);   // stored patterns survive reset

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
